// File: rtl/doodle_object_renderer.sv
// doodle_object_renderer
//   Pixel-side renderer for the doodle (ball) and the cannon. Object state
//   from the jump logic is snapshotted once per frame on a synchronised
//   frame_clk rising edge, so an object never tears within a frame. Each
//   pixel goes through a fixed 2-cycle pipeline:
//     S1: hit tests, sprite address, size-match flag
//     S2: sprite ROM lookup, colour priority, output registers
//
// Ports
//   Clk, Reset                   pixel clock, async active-high reset
//   frame_clk                    vsync-rate strobe (asynchronous to Clk)
//   DrawX, DrawY, blank          pixel coordinate, 1 = active video
//   BallX/BallY/BallS            doodle centre and half-size
//   CannonX/CannonY/CannonS      cannon centre and half-size
//   outstate                     000 start, 001 play, 010 over
//   Red, Green, Blue             pixel colour (2 cycles after DrawX/DrawY)
//   obj_hit                      {cannon_hit, ball_hit}, qualified by blank
//   facing_left                  doodle facing, updated at the frame edge
module doodle_object_renderer #(
  parameter logic [9:0]  SPRITE_HALF  = 10'd12,
  parameter logic [23:0] BG_COLOR     = 24'hC8E6FF,
  parameter logic [23:0] CANNON_COLOR = 24'h202020,
  parameter logic [23:0] BOX_COLOR    = 24'h40C040,
  parameter logic [23:0] OVER_TINT    = 24'hFF0000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  input  logic [9:0] CannonX,
  input  logic [9:0] CannonY,
  input  logic [9:0] CannonS,
  input  logic [2:0] outstate,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic [1:0] obj_hit,
  output logic       facing_left
);

  localparam logic [2:0] ST_PLAY = 3'b001;
  localparam logic [2:0] ST_OVER = 3'b010;

  localparam logic [23:0] PAL_1 = 24'hF0D040;
  localparam logic [23:0] PAL_2 = 24'h60A030;
  localparam logic [23:0] PAL_3 = 24'h804020;

  // Span test in 12-bit signed so C+S never overflows; results are the same
  // as 11-bit arithmetic for every in-range position. S = 0 gives lo == hi.
  function automatic logic in_span(input logic [9:0] d, input logic [9:0] c,
                                   input logic [9:0] s);
    logic signed [11:0] dd;
    logic signed [11:0] lo;
    logic signed [11:0] hi;
    dd = $signed({2'b00, d});
    lo = $signed({2'b00, c}) - $signed({2'b00, s});
    hi = $signed({2'b00, c}) + $signed({2'b00, s});
    return (dd >= lo) && (dd < hi);
  endfunction

  // 24x24 doodle sprite, 2-bit palette index, 0 = transparent.
  // Entry (row, col) holds (row + 3*col) mod 4.
  function automatic logic [1:0] rom_index(input logic [9:0] addr);
    logic [9:0] r;
    logic [9:0] c;
    logic [9:0] sum;
    r   = addr / 10'd24;
    c   = addr % 10'd24;
    sum = r + c + c + c;
    return sum[1:0];
  endfunction

  // ---------------- frame strobe synchroniser + edge detect ----------------
  logic [2:0] fsync;
  logic       frame_edge;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) fsync <= 3'b000;
    else       fsync <= {fsync[1:0], frame_clk};
  end

  assign frame_edge = fsync[1] & ~fsync[2];

  // ---------------- per-frame shadow registers ----------------
  logic [9:0] ball_x, ball_y, ball_s;
  logic [9:0] cannon_x, cannon_y, cannon_s;
  logic [2:0] state_q;

  logic signed [10:0] dx;
  logic        [10:0] dx_abs;
  logic               facing_nxt;

  assign dx     = $signed({1'b0, BallX}) - $signed({1'b0, ball_x});
  assign dx_abs = dx[10] ? 11'(-dx) : 11'(dx);

  // A jump of half the screen or more is the doodle wrapping around the
  // edge, so its real motion is opposite to the sign of dx.
  always_comb begin
    facing_nxt = facing_left;
    if (dx != 11'sd0) begin
      if (dx_abs < 11'd320) facing_nxt = dx[10];
      else                  facing_nxt = ~dx[10];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ball_x      <= 10'd320;
      ball_y      <= 10'd240;
      ball_s      <= 10'd12;
      cannon_x    <= 10'd0;
      cannon_y    <= 10'd0;
      cannon_s    <= 10'd2;
      state_q     <= 3'b000;
      facing_left <= 1'b0;
    end else if (frame_edge) begin
      ball_x      <= BallX;
      ball_y      <= BallY;
      ball_s      <= BallS;
      cannon_x    <= CannonX;
      cannon_y    <= CannonY;
      cannon_s    <= CannonS;
      state_q     <= outstate;
      facing_left <= facing_nxt;
    end
  end

  // ---------------- S1: hit test and sprite address ----------------
  logic       ball_hit, cannon_hit;
  logic [9:0] col_raw, row_raw;
  logic [4:0] col_sel;
  logic [9:0] sprite_addr;

  assign ball_hit   = in_span(DrawX, ball_x, ball_s) & in_span(DrawY, ball_y, ball_s);
  assign cannon_hit = in_span(DrawX, cannon_x, cannon_s) & in_span(DrawY, cannon_y, cannon_s);

  // Offsets from the sprite's top-left corner; only meaningful on a ball hit
  // with the size matching the ROM, where both are 0..23.
  assign col_raw     = DrawX + ball_s - ball_x;
  assign row_raw     = DrawY + ball_s - ball_y;
  assign col_sel     = facing_left ? (5'd23 - col_raw[4:0]) : col_raw[4:0];
  assign sprite_addr = ({5'd0, row_raw[4:0]} * 10'd24) + {5'd0, col_sel};

  logic       s1_valid, s1_ball_hit, s1_cannon_hit, s1_size_ok;
  logic [9:0] s1_addr;
  logic [2:0] s1_state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid      <= 1'b0;
      s1_ball_hit   <= 1'b0;
      s1_cannon_hit <= 1'b0;
      s1_size_ok    <= 1'b0;
      s1_addr       <= 10'd0;
      s1_state      <= 3'b000;
    end else begin
      s1_valid      <= blank;
      s1_ball_hit   <= blank & ball_hit;
      s1_cannon_hit <= blank & cannon_hit;
      s1_size_ok    <= (ball_s == SPRITE_HALF);
      s1_addr       <= sprite_addr;
      s1_state      <= state_q;
    end
  end

  // ---------------- S2: ROM, colour priority ----------------
  logic [1:0]  rom_idx;
  logic        opaque, show_ball, show_cannon;
  logic [23:0] doodle_rgb, pix_rgb;

  always_comb begin
    rom_idx     = rom_index(s1_addr);
    show_cannon = (s1_state == ST_PLAY);
    show_ball   = (s1_state == ST_PLAY) || (s1_state == ST_OVER);
    opaque      = s1_ball_hit && (!s1_size_ok || (rom_idx != 2'd0));

    doodle_rgb = BOX_COLOR;
    if (s1_size_ok) begin
      case (rom_idx)
        2'd1:    doodle_rgb = PAL_1;
        2'd2:    doodle_rgb = PAL_2;
        default: doodle_rgb = PAL_3;
      endcase
    end
    if (s1_state == ST_OVER) doodle_rgb = OVER_TINT;

    if (!s1_valid)                        pix_rgb = 24'h000000;
    else if (s1_cannon_hit && show_cannon) pix_rgb = CANNON_COLOR;
    else if (opaque && show_ball)          pix_rgb = doodle_rgb;
    else                                   pix_rgb = BG_COLOR;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Red     <= 8'd0;
      Green   <= 8'd0;
      Blue    <= 8'd0;
      obj_hit <= 2'b00;
    end else begin
      Red     <= pix_rgb[23:16];
      Green   <= pix_rgb[15:8];
      Blue    <= pix_rgb[7:0];
      obj_hit <= {s1_cannon_hit, s1_ball_hit};
    end
  end

endmodule

// File: tb/tb_doodle_object_renderer.sv
module tb_doodle_object_renderer;

  localparam logic [23:0] BG   = 24'hC8E6FF;
  localparam logic [23:0] CAN  = 24'h202020;
  localparam logic [23:0] BOX  = 24'h40C040;
  localparam logic [23:0] OVR  = 24'hFF0000;
  localparam logic [23:0] PAL1 = 24'hF0D040;
  localparam logic [23:0] PAL2 = 24'h60A030;
  localparam logic [23:0] PAL3 = 24'h804020;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [9:0] DrawX, DrawY;
  logic       blank;
  logic [9:0] BallX, BallY, BallS;
  logic [9:0] CannonX, CannonY, CannonS;
  logic [2:0] outstate;
  logic [7:0] Red, Green, Blue;
  logic [1:0] obj_hit;
  logic       facing_left;

  int n_vec = 0;
  int n_bad = 0;

  doodle_object_renderer dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .CannonX(CannonX), .CannonY(CannonY), .CannonS(CannonS),
    .outstate(outstate),
    .Red(Red), .Green(Green), .Blue(Blue),
    .obj_hit(obj_hit), .facing_left(facing_left)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a pixel, then check RGB and obj_hit exactly two clocks later.
  task automatic pix(input string tag, input int x, input int y, input logic b,
                     input logic [23:0] exp_rgb, input logic [1:0] exp_hit);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk({tag, ".rgb"}, {8'h0, Red, Green, Blue}, {8'h0, exp_rgb});
    chk({tag, ".hit"}, {30'h0, obj_hit}, {30'h0, exp_hit});
  endtask

  task automatic frame(input int bx, input int by, input int bs,
                       input int cx, input int cy, input int cs, input logic [2:0] st);
    @(negedge Clk);
    BallX = 10'(bx); BallY = 10'(by); BallS = 10'(bs);
    CannonX = 10'(cx); CannonY = 10'(cy); CannonS = 10'(cs);
    outstate = st;
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; blank = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0;
    BallX = 10'd320; BallY = 10'd240; BallS = 10'd12;
    CannonX = 10'd0; CannonY = 10'd0; CannonS = 10'd2;
    outstate = 3'b000;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst.rgb", {8'h0, Red, Green, Blue}, 32'h0);
    chk("rst.hit", {30'h0, obj_hit}, 32'h0);
    chk("rst.face", {31'h0, facing_left}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    // Shadow after reset: ball 320/240/12, state 000 -> objects hidden,
    // centre sprite entry (12,12) is transparent anyway; raw hit still reported.
    pix("t1.centre", 320, 240, 1'b1, BG, 2'b01);

    // 320 -> 318: moving left. Sprite spans x 306..329, y 228..251.
    frame(318, 240, 12, 0, 0, 2, 3'b001);
    chk("t2.face", {31'h0, facing_left}, 32'h1);
    pix("t2.tl",   306, 228, 1'b1, PAL1, 2'b01);  // col 0 -> 23, row 0: 69 mod 4 = 1
    pix("t2.tl1",  307, 228, 1'b1, PAL2, 2'b01);  // col 1 -> 22: 66 mod 4 = 2
    pix("t2.br",   329, 251, 1'b1, PAL3, 2'b01);  // col 23 -> 0, row 23: 3
    pix("t2.left", 305, 228, 1'b1, BG,   2'b00);
    pix("t2.rgt",  330, 240, 1'b1, BG,   2'b00);  // upper bound exclusive

    // 318 -> 627 (dx 309, right), then 627 -> 12 (dx -615, wrap = right).
    frame(627, 240, 12, 0, 0, 2, 3'b001);
    chk("t3.face627", {31'h0, facing_left}, 32'h0);
    frame(12, 240, 12, 0, 0, 2, 3'b001);
    chk("t3.face12", {31'h0, facing_left}, 32'h0);
    pix("t3.x0",   0,   240, 1'b1, BG,   2'b01);  // col 0 row 12: transparent
    pix("t3.x1",   1,   240, 1'b1, PAL3, 2'b01);  // col 1 row 12: 15 mod 4 = 3
    pix("t3.x639", 639, 240, 1'b1, BG,   2'b00);
    // 12 -> 630 (dx 618, wrap = left).
    frame(630, 240, 12, 0, 0, 2, 3'b001);
    chk("t3.face630", {31'h0, facing_left}, 32'h1);
    pix("t3.e639", 639, 240, 1'b1, PAL2, 2'b01);  // col 21 -> 2, row 12: 18 mod 4 = 2
    pix("t3.e0",   0,   240, 1'b1, BG,   2'b00);

    // 630 -> 100 (dx -530, wrap = right). Cannon 98..101 over the ball.
    frame(100, 100, 12, 100, 100, 2, 3'b001);
    chk("t4.face", {31'h0, facing_left}, 32'h0);
    pix("t4.c98",   98,  98, 1'b1, CAN,  2'b11);
    pix("t4.c101", 101, 101, 1'b1, CAN,  2'b11);
    pix("t4.b102", 102, 100, 1'b1, PAL2, 2'b01);  // col 14 row 12: 54 mod 4 = 2
    pix("t4.b97",   97, 100, 1'b1, PAL3, 2'b01);  // col 9 row 12: 39 mod 4 = 3
    pix("t4.y97",  100,  97, 1'b1, PAL1, 2'b01);  // col 12 row 9: 45 mod 4 = 1

    // Inputs change without a frame edge: render must not move.
    @(negedge Clk);
    BallX = 10'd400; BallS = 10'd8;
    repeat (4) @(negedge Clk);
    pix("t5.hold", 102, 100, 1'b1, PAL2, 2'b01);
    frame(400, 100, 8, 100, 100, 2, 3'b001);
    pix("t5.box0",  392, 100, 1'b1, BOX, 2'b01);
    pix("t5.box1",  407, 107, 1'b1, BOX, 2'b01);
    pix("t5.boxt",  400,  92, 1'b1, BOX, 2'b01);
    pix("t5.out_r", 408, 100, 1'b1, BG,  2'b00);
    pix("t5.out_l", 391, 100, 1'b1, BG,  2'b00);
    pix("t5.out_t", 400,  91, 1'b1, BG,  2'b00);

    pix("t6.blank", 400, 100, 1'b0, 24'h0, 2'b00);
    frame(400, 100, 12, 100, 100, 2, 3'b010);
    pix("t6.over",  401, 100, 1'b1, OVR, 2'b01);  // col 13 row 12: 51 mod 4 = 3
    pix("t6.trans", 400, 100, 1'b1, BG,  2'b01);  // col 12 row 12: transparent
    pix("t6.can",   100, 100, 1'b1, BG,  2'b10);  // cannon hidden in 010
    frame(400, 100, 12, 100, 100, 2, 3'b011);
    pix("t6.st3",   401, 100, 1'b1, BG,  2'b01);

    // 400 -> 350: left. Pixel col 13 -> 10, row 12: 42 mod 4 = 2.
    frame(350, 100, 12, 100, 100, 2, 3'b001);
    chk("t6.face", {31'h0, facing_left}, 32'h1);
    pix("t6.pre", 351, 100, 1'b1, PAL2, 2'b01);
    #2;
    Reset = 1'b1;
    #1;
    chk("t6.rst.rgb",  {8'h0, Red, Green, Blue}, 32'h0);
    chk("t6.rst.hit",  {30'h0, obj_hit}, 32'h0);
    chk("t6.rst.face", {31'h0, facing_left}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    chk("t6.post1", {8'h0, Red, Green, Blue}, 32'h0);
    @(posedge Clk);
    #1;
    // Shadow back to 320/240/12, state 000: background, no hit at (351,100).
    chk("t6.post2", {8'h0, Red, Green, Blue}, {8'h0, BG});
    chk("t6.post2h", {30'h0, obj_hit}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
